// File: rtl/word_dispatch_arbiter.sv
// Round-robin word dispatcher feeding N descrypt cores, with config drain sequencing.
// Optional dispatch counter enabled by WORD_DISPATCH_STATS_EN.
module word_dispatch_arbiter #(
  parameter int N_CORES     = 4,
  parameter int WORD_WIDTH  = 56,
  parameter int ID_WIDTH    = 65,
  parameter int DRAIN_GUARD = 2
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [WORD_WIDTH-1:0] word_in,
  input  logic [ID_WIDTH-1:0]   ids_in,
  input  logic                  word_wr_en,
  output logic                  word_full,
  input  logic                  new_cmp_config,
  output logic                  config_applied,
  input  logic [N_CORES-1:0]    core_full,
  input  logic [N_CORES-1:0]    core_idle,
  output logic [N_CORES-1:0]    core_wr_en,
  output logic [WORD_WIDTH-1:0] core_word,
  output logic [ID_WIDTH-1:0]   core_ids,
  output logic                  busy,
  output logic [31:0]           num_dispatched
);

  localparam int PTR_W = $clog2(N_CORES);
  localparam int GRD_W =
    (DRAIN_GUARD < 1) ? 1 : $clog2(DRAIN_GUARD + 1);

  typedef enum logic [1:0] {
    RUN,
    DRAIN,
    APPLY
  } state_t;

  state_t                state;
  logic                  hold_valid;
  logic [WORD_WIDTH-1:0] hold_word;
  logic [ID_WIDTH-1:0]   hold_ids;
  logic [PTR_W-1:0]      rr_ptr;
  logic                  cfg_pending;
  logic [GRD_W-1:0]      guard;

  logic [PTR_W-1:0]      grant;
  logic                  grant_ok;
  logic [PTR_W:0]        cand;
  logic [PTR_W-1:0]      next_ptr;
  logic                  dispatch;
  logic                  accept;
  logic                  all_idle;

  // first free core at or after rr_ptr, wrapping modulo N_CORES
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    cand     = '0;
    for (int i = 0; i < N_CORES; i++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(i);
      if (cand >= (PTR_W+1)'(N_CORES)) begin
        cand = cand - (PTR_W+1)'(N_CORES);
      end
      if (!grant_ok && !core_full[cand[PTR_W-1:0]]) begin
        grant_ok = 1'b1;
        grant    = cand[PTR_W-1:0];
      end
    end
  end

  assign dispatch = hold_valid & grant_ok;
  assign next_ptr = (grant == PTR_W'(N_CORES - 1)) ?
                    '0 : grant + 1'b1;

  assign core_wr_en = dispatch ?
                      (N_CORES'(1) << grant) : '0;
  assign core_word  = hold_word;
  assign core_ids   = hold_ids;

  assign word_full = (state != RUN) |
                     (hold_valid & ~dispatch);
  assign accept    = word_wr_en & ~word_full;
  assign busy      = (state != RUN) | hold_valid;
  assign all_idle  = &core_idle;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      hold_valid <= 1'b0;
      hold_word  <= '0;
      hold_ids   <= '0;
    end else if (accept) begin
      hold_valid <= 1'b1;
      hold_word  <= word_in;
      hold_ids   <= ids_in;
    end else if (dispatch) begin
      hold_valid <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rr_ptr <= '0;
    end else if (dispatch) begin
      rr_ptr <= next_ptr;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state          <= RUN;
      cfg_pending    <= 1'b0;
      guard          <= '0;
      config_applied <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          guard          <= '0;
          config_applied <= 1'b0;
          if (new_cmp_config) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (new_cmp_config) begin
            cfg_pending <= 1'b1;
          end
          if (dispatch || !all_idle) begin
            guard <= '0;
          end else if (guard != GRD_W'(DRAIN_GUARD)) begin
            guard <= guard + 1'b1;
          end
          if (!hold_valid &&
              guard == GRD_W'(DRAIN_GUARD)) begin
            state          <= APPLY;
            config_applied <= 1'b1;
          end
        end
        APPLY: begin
          config_applied <= 1'b0;
          guard          <= '0;
          // a request landing during drain/apply re-drains immediately
          if (cfg_pending || new_cmp_config) begin
            cfg_pending <= 1'b0;
            state       <= DRAIN;
          end else begin
            state <= RUN;
          end
        end
        default: begin
          state          <= RUN;
          config_applied <= 1'b0;
        end
      endcase
    end
  end

`ifdef WORD_DISPATCH_STATS_EN
  logic [31:0] disp_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      disp_cnt <= '0;
    end else if (dispatch && disp_cnt != 32'hFFFF_FFFF) begin
      disp_cnt <= disp_cnt + 32'd1;
    end
  end

  assign num_dispatched = disp_cnt;
`else
  assign num_dispatched = '0;
`endif

endmodule

// File: tb/tb_word_dispatch_arbiter.sv
// Directed self-checking bench for word_dispatch_arbiter (N_CORES=4).
// Honours WORD_DISPATCH_STATS_EN for the dispatch counter expectation.
module tb_word_dispatch_arbiter;

  localparam int NC = 4;
  localparam int WW = 56;
  localparam int IW = 65;

  logic          CLK;
  logic          RST_N;
  logic [WW-1:0] word_in;
  logic [IW-1:0] ids_in;
  logic          word_wr_en;
  logic          word_full;
  logic          new_cmp_config;
  logic          config_applied;
  logic [NC-1:0] core_full;
  logic [NC-1:0] core_idle;
  logic [NC-1:0] core_wr_en;
  logic [WW-1:0] core_word;
  logic [IW-1:0] core_ids;
  logic          busy;
  logic [31:0]   num_dispatched;

  int checks;
  int failures;

  word_dispatch_arbiter #(
    .N_CORES    (NC),
    .WORD_WIDTH (WW),
    .ID_WIDTH   (IW),
    .DRAIN_GUARD(2)
  ) dut (
    .CLK           (CLK),
    .RST_N         (RST_N),
    .word_in       (word_in),
    .ids_in        (ids_in),
    .word_wr_en    (word_wr_en),
    .word_full     (word_full),
    .new_cmp_config(new_cmp_config),
    .config_applied(config_applied),
    .core_full     (core_full),
    .core_idle     (core_idle),
    .core_wr_en    (core_wr_en),
    .core_word     (core_word),
    .core_ids      (core_ids),
    .busy          (busy),
    .num_dispatched(num_dispatched)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [IW-1:0] mk_ids(int wid);
    return {1'b0, 32'h0000_0001, 16'(wid), 16'h0007};
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST_N          = 1'b0;
    word_wr_en     = 1'b0;
    new_cmp_config = 1'b0;
    core_full      = '0;
    core_idle      = '1;
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N          = 1'b0;
    word_in        = '0;
    ids_in         = '0;
    word_wr_en     = 1'b0;
    new_cmp_config = 1'b0;
    core_full      = '0;
    core_idle      = '1;
    @(negedge CLK);
    checks++;
    if ({core_wr_en, config_applied, word_full, busy}
        !== 7'b0) begin
      failures++;
      $display("FAIL reset_ctrl: got wr=%b ca=%b wf=%b bz=%b want 0",
               core_wr_en, config_applied, word_full, busy);
    end
    checks++;
    if (core_word !== '0 || core_ids !== '0 ||
        num_dispatched !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: got w=%h i=%h n=%0d want 0",
               core_word, core_ids, num_dispatched);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic [NC-1:0] exp_wr;
    for (int i = 0; i <= 8; i++) begin
      word_wr_en = (i < 8);
      word_in    = WW'(56'h100 + i);
      ids_in     = mk_ids(i);
      @(negedge CLK);
      checks++;
      if (word_full !== 1'b0) begin
        failures++;
        $display("FAIL b2b_full c%0d: got %b want 0", i, word_full);
      end
      exp_wr = (i == 0) ? 4'b0 : 4'(1 << ((i - 1) % 4));
      checks++;
      if (core_wr_en !== exp_wr) begin
        failures++;
        $display("FAIL b2b_wr c%0d: got %b want %b",
                 i, core_wr_en, exp_wr);
      end
      if (i > 0) begin
        checks++;
        if (core_word !== WW'(56'h100 + i - 1) ||
            core_ids !== mk_ids(i - 1)) begin
          failures++;
          $display("FAIL b2b_data c%0d: got %h want %h",
                   i, core_word, WW'(56'h100 + i - 1));
        end
      end
      tick();
    end
    word_wr_en = 1'b0;
  endtask

  task automatic test_skip_full();
    logic [NC-1:0] exp_seq [4];
    exp_seq[0] = 4'b0010;
    exp_seq[1] = 4'b1000;
    exp_seq[2] = 4'b0010;
    exp_seq[3] = 4'b1000;
    core_full = 4'b0101;
    for (int i = 0; i <= 4; i++) begin
      word_wr_en = (i < 4);
      word_in    = WW'(56'h200 + i);
      ids_in     = mk_ids(16 + i);
      @(negedge CLK);
      if (i > 0) begin
        checks++;
        if (core_wr_en !== exp_seq[i-1]) begin
          failures++;
          $display("FAIL skip_wr c%0d: got %b want %b",
                   i, core_wr_en, exp_seq[i-1]);
        end
      end
      tick();
    end
    word_wr_en = 1'b0;
    core_full  = '0;
  endtask

  task automatic test_all_full();
    core_full  = 4'hF;
    word_wr_en = 1'b1;
    word_in    = WW'(56'hA5A5);
    ids_in     = mk_ids(40);
    tick();
    word_wr_en = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      @(negedge CLK);
      checks++;
      if (word_full !== 1'b1 || core_wr_en !== 4'b0 ||
          busy !== 1'b1) begin
        failures++;
        $display("FAIL allfull c%0d: got wf=%b wr=%b bz=%b want 1,0,1",
                 i, word_full, core_wr_en, busy);
      end
      tick();
    end
    core_full = 4'b1011;
    @(negedge CLK);
    checks++;
    if (core_wr_en !== 4'b0100 || word_full !== 1'b0 ||
        core_word !== WW'(56'hA5A5)) begin
      failures++;
      $display("FAIL allfull_release: got wr=%b wf=%b w=%h want 0100,0,a5a5",
               core_wr_en, word_full, core_word);
    end
    tick();
    core_full = '0;
  endtask

  task automatic test_config_drain();
    logic exp_ca;
    core_full  = 4'hF;
    word_wr_en = 1'b1;
    word_in    = WW'(56'hBEEF);
    ids_in     = mk_ids(50);
    tick();
    word_wr_en     = 1'b0;
    new_cmp_config = 1'b1;
    core_idle      = '0;
    @(negedge CLK);
    checks++;
    if (word_full !== 1'b1) begin
      failures++;
      $display("FAIL drain_full_now: got %b want 1", word_full);
    end
    tick();
    new_cmp_config = 1'b0;
    core_full      = '0;
    @(negedge CLK);
    checks++;
    if (core_wr_en !== 4'b1000 || word_full !== 1'b1 ||
        core_word !== WW'(56'hBEEF)) begin
      failures++;
      $display("FAIL drain_dispatch: got wr=%b wf=%b w=%h want 1000,1,beef",
               core_wr_en, word_full, core_word);
    end
    tick();
    for (int i = 3; i <= 11; i++) begin
      @(negedge CLK);
      checks++;
      if (config_applied !== 1'b0 || word_full !== 1'b1) begin
        failures++;
        $display("FAIL drain_wait c%0d: got ca=%b wf=%b want 0,1",
                 i, config_applied, word_full);
      end
      tick();
    end
    core_idle = '1;
    for (int j = 0; j <= 3; j++) begin
      exp_ca = (j == 3);
      @(negedge CLK);
      checks++;
      if (config_applied !== exp_ca) begin
        failures++;
        $display("FAIL drain_pulse k+%0d: got %b want %b",
                 j, config_applied, exp_ca);
      end
      tick();
    end
    word_wr_en = 1'b1;
    word_in    = WW'(56'hCAFE);
    ids_in     = mk_ids(51);
    @(negedge CLK);
    checks++;
    if (word_full !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL drain_resume: got wf=%b bz=%b want 0,0",
               word_full, busy);
    end
    tick();
    word_wr_en = 1'b0;
    @(negedge CLK);
    checks++;
    if (core_wr_en !== 4'b0001 || core_word !== WW'(56'hCAFE)) begin
      failures++;
      $display("FAIL drain_after: got wr=%b w=%h want 0001,cafe",
               core_wr_en, core_word);
    end
    tick();
  endtask

  task automatic test_double_config();
    int  pulses;
    logic exp_ca;
    logic exp_wf;
    pulses = 0;
    for (int c = 0; c <= 12; c++) begin
      new_cmp_config = (c == 0 || c == 3);
      exp_ca = (c == 4 || c == 8);
      exp_wf = (c >= 1 && c <= 8);
      @(negedge CLK);
      if (config_applied === 1'b1) pulses++;
      checks++;
      if (config_applied !== exp_ca || word_full !== exp_wf) begin
        failures++;
        $display("FAIL dbl_cfg c%0d: got ca=%b wf=%b want %b,%b",
                 c, config_applied, word_full, exp_ca, exp_wf);
      end
      tick();
    end
    new_cmp_config = 1'b0;
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL dbl_cfg_count: got %0d want 2", pulses);
    end
  endtask

  task automatic test_stats();
    logic [31:0] exp_n;
`ifdef WORD_DISPATCH_STATS_EN
    exp_n = 32'd10;
`else
    exp_n = 32'd0;
`endif
    do_reset();
    for (int c = 0; c <= 10; c++) begin
      word_wr_en = (c < 10);
      word_in    = WW'(56'h300 + c);
      ids_in     = mk_ids(60 + c);
      tick();
    end
    word_wr_en = 1'b0;
    @(negedge CLK);
    checks++;
    if (num_dispatched !== exp_n) begin
      failures++;
      $display("FAIL stats_count: got %0d want %0d",
               num_dispatched, exp_n);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    core_full  = 4'hF;
    word_wr_en = 1'b1;
    word_in    = WW'(56'hD00D);
    ids_in     = mk_ids(70);
    tick();
    word_wr_en     = 1'b0;
    new_cmp_config = 1'b1;
    core_idle      = '0;
    tick();
    new_cmp_config = 1'b0;
    core_full      = '0;
    @(negedge CLK);
    checks++;
    if (core_wr_en !== 4'b0100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL rst_pre: got wr=%b bz=%b want 0100,1",
               core_wr_en, busy);
    end
    #1;
    RST_N = 1'b0;
    #1;
    checks++;
    if ({core_wr_en, config_applied, word_full, busy}
        !== 7'b0 || core_word !== '0 || core_ids !== '0 ||
        num_dispatched !== 32'd0) begin
      failures++;
      $display("FAIL rst_async: got wr=%b ca=%b wf=%b bz=%b w=%h n=%0d want 0",
               core_wr_en, config_applied, word_full, busy,
               core_word, num_dispatched);
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N     = 1'b1;
    core_idle = '1;
    tick();
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      checks++;
      if (config_applied !== 1'b0 || busy !== 1'b0) begin
        failures++;
        $display("FAIL rst_after c%0d: got ca=%b bz=%b want 0,0",
                 i, config_applied, busy);
      end
      tick();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_back_to_back();
    test_skip_full();
    test_all_full();
    test_config_drain();
    test_double_config();
    test_stats();
    test_reset_mid_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/word_dispatch_arbiter.md
Name: word_dispatch_arbiter

Overview:
- Sits between the word_gen output register and N descrypt cores, all on WORD_GEN_CLK.
- Distributes candidate words round-robin to cores with free input space.
- Sequences comparator-config changes:
  - On a new config request, stops accepting words and dispatches the word still held.
  - Waits until every core is idle, then pulses config_applied.
  - Resumes dispatch afterwards.

Parameters:
- N_CORES, 4, number of cores served (2..16).
- WORD_WIDTH, 56, candidate word width (WORD_MAX_LEN*CHAR_BITS).
- ID_WIDTH, 65, packed {gen_end, gen_id[31:0], word_id[15:0], pkt_id[15:0]}.
- DRAIN_GUARD, 2, cycles core_idle must hold after last dispatch before apply.

Ports:
- CLK  in  1  WORD_GEN_CLK domain clock
- RST_N  in  1  asynchronous active-low reset
- word_in  in  WORD_WIDTH  candidate word from word_gen register
- ids_in  in  ID_WIDTH  packed IDs accompanying word_in
- word_wr_en  in  1  producer write strobe; legal only when word_full=0
- word_full  out  1  arbiter cannot accept a word this cycle
- new_cmp_config  in  1  single-cycle request: new config pending
- config_applied  out  1  single-cycle pulse: cores drained, config may be switched
- core_full  in  N_CORES  per-core input not ready
- core_idle  in  N_CORES  per-core pipeline empty
- core_wr_en  out  N_CORES  one-hot write strobe to selected core
- core_word  out  WORD_WIDTH  word broadcast to all cores
- core_ids  out  ID_WIDTH  IDs broadcast to all cores
- busy  out  1  state != RUN or hold register valid
- num_dispatched  out  32  dispatched-word count (see Optional Feature)

Behaviour:
- Reset (RST_N=0, async):
  - state=RUN, hold_valid=0, rr_ptr=0, cfg_pending=0, guard=0.
  - Outputs: core_wr_en=0, config_applied=0, word_full=0, busy=0, num_dispatched=0.
  - core_word/core_ids = 0.
- Hold register (one entry):
  - Loads word_in/ids_in on word_wr_en & ~word_full.
  - core_word/core_ids are driven directly from the hold register.
- Grant:
  - Combinational.
  - First core c with ~core_full[c], searching from rr_ptr upward with wrap at N_CORES-1 -> 0.
- Dispatch:
  - dispatch = hold_valid & any free core.
  - core_wr_en = one-hot of grant when dispatch, else 0.
  - On dispatch, rr_ptr <= grant+1, wrapping to 0 when grant+1 = N_CORES.
- Latency: word written at cycle t is dispatched at t+1 at the earliest.
- Throughput: one word/cycle.
- word_full = (state != RUN) | (hold_valid & ~dispatch).
  - Simultaneous dispatch and new write in one cycle is legal; the hold register is reloaded.
- All cores full: hold_valid stays set, core_wr_en=0, word_full=1, no pointer change.
- State machine (RUN, DRAIN, APPLY):
  - RUN: new_cmp_config -> DRAIN.
  - DRAIN:
    - No new words accepted; the held word is still dispatched.
    - guard resets to 0 on any dispatch or when &core_idle=0, else increments (saturating).
    - Go to APPLY when hold_valid=0 and guard=DRAIN_GUARD.
  - APPLY: config_applied=1 for exactly one cycle -> RUN.
- new_cmp_config during DRAIN or APPLY:
  - Sets cfg_pending.
  - On leaving APPLY with cfg_pending=1: clear it and go straight to DRAIN, not RUN.
  - Every request yields exactly one config_applied.
- new_cmp_config in RUN in the same cycle as word_wr_en: the write is accepted, because word_full is registered state; that word is dispatched during DRAIN.
- busy = (state != RUN) | hold_valid.
- Reset mid-DRAIN: held word discarded, no config_applied pulse.

Optional Feature:
- Macro: WORD_DISPATCH_STATS_EN.
- Defined: num_dispatched increments on every dispatch and saturates at 32'hFFFF_FFFF (no wrap).
  - Cleared only by reset.
- Undefined: num_dispatched tied to 0; no counter logic instantiated.

Test Plan:
- N_CORES=4, all cores free; 8 back-to-back words (word_id 0..7) -> core_wr_en one-hot sequence 1,2,4,8,1,2,4,8 on cycles t+1..t+8; word_full stays 0.
- core_full=4'b0101, 4 words -> words go to cores 1,3,1,3; rr_ptr skips full cores; no cycle with two bits set.
- core_full=4'hF for 5 cycles with one word held -> word_full=1 and core_wr_en=0 throughout; core_full[2] drops -> word dispatched to core 2 next cycle, word_full=0 that same cycle.
- new_cmp_config with word held, core_idle=0 for 10 cycles then 4'hF -> word_full=1 immediately; held word dispatched; config_applied single pulse exactly DRAIN_GUARD+1 cycles after idle rises; RUN resumes after.
- Two new_cmp_config pulses 3 cycles apart -> exactly two config_applied pulses; no word accepted between them.
- RST_N low mid-DRAIN with hold_valid=1 -> all outputs 0 immediately (async); no config_applied; num_dispatched=0; with WORD_DISPATCH_STATS_EN, 10 dispatches before reset read back 10.
